// File: rtl/usr_xfer_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usr_xfer_ctrl_if                                                           |
// | Command/response bus plus shift-register control bundle for usr_xfer_ctrl. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface usr_xfer_ctrl_if #(
  parameter int W     = 5,
  parameter int CNT_W = 3
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [W-1:0]     cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_si;
  logic             cmd_rot;

  logic [1:0]       usr_sel;
  logic [W-1:0]     usr_pi;
  logic             usr_si;
  logic [W-1:0]     usr_po;
  logic             usr_so;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic [W-1:0]     rsp_shout;

  logic             busy;

  // Requester and shift register side
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_si, cmd_rot,
    input  cmd_ready,
    input  usr_sel, usr_pi, usr_si,
    output usr_po, usr_so,
    input  rsp_valid, rsp_data, rsp_shout,
    output rsp_ready,
    input  busy
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_si, cmd_rot,
    output cmd_ready,
    output usr_sel, usr_pi, usr_si,
    input  usr_po, usr_so,
    output rsp_valid, rsp_data, rsp_shout,
    input  rsp_ready,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/usr_xfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usr_xfer_ctrl                                                              |
// | Sequences load/shift/rotate/read commands onto a universal shift register. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module usr_xfer_ctrl #(
  parameter int W     = 5,
  parameter int CNT_W = 3
) (
  input  wire logic     clk,
  input  wire logic     rst,
  usr_xfer_ctrl_if.slave bus
);

  localparam logic [1:0]       OP_READ = 2'b00;
  localparam logic [1:0]       OP_SHL  = 2'b01;
  localparam logic [1:0]       OP_SHR  = 2'b10;
  localparam logic [1:0]       OP_LOAD = 2'b11;
  localparam logic [1:0]       SEL_HOLD = 2'b00;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             si_q, si_d;
  logic             rot_q, rot_d;
  logic [W-1:0]     cap_q, cap_d;

  logic             ready;
  logic [1:0]       sel;
  logic [W-1:0]     pi;
  logic             si;
  logic             rsp_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      data_q  <= '0;
      cnt_q   <= '0;
      si_q    <= 1'b0;
      rot_q   <= 1'b0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      si_q    <= si_d;
      rot_q   <= rot_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    si_d    = si_q;
    rot_d   = rot_q;
    cap_d   = cap_q;
    ready   = 1'b0;
    sel     = SEL_HOLD;
    pi      = '0;
    si      = 1'b0;
    rsp_vld = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          cnt_d  = bus.cmd_count;
          si_d   = bus.cmd_si;
          rot_d  = bus.cmd_rot;
          cap_d  = '0;
          case (bus.cmd_op)
            OP_LOAD: state_d = S_LOAD;
            OP_SHL, OP_SHR: begin
              state_d = (bus.cmd_count != CNT_ZERO) ? S_SHIFT : S_RESP;
            end
            default: state_d = S_RESP;
          endcase
        end
      end

      S_LOAD: begin
        sel     = OP_LOAD;
        pi      = data_q;
        state_d = S_RESP;
      end

      // SO is a function of registered sel and PO only, so feeding it back
      // into SI for rotation does not form a combinational loop.
      S_SHIFT: begin
        sel   = op_q;
        si    = rot_q ? bus.usr_so : si_q;
        cap_d = {cap_q[W-2:0], bus.usr_so};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        rsp_vld = 1'b1;
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // An in-flight command is abandoned in the reset cycle itself
    if (rst) begin
      ready   = 1'b0;
      sel     = SEL_HOLD;
      pi      = '0;
      si      = 1'b0;
      rsp_vld = 1'b0;
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.usr_sel   = sel;
  assign bus.usr_pi    = pi;
  assign bus.usr_si    = si;
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_data  = bus.usr_po;
  assign bus.rsp_shout = cap_q;
  assign bus.busy      = (state_q != S_IDLE) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_usr_xfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_usr_xfer_ctrl                                                           |
// | Directed bench for usr_xfer_ctrl with a behavioural shift register model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_usr_xfer_ctrl;

  localparam int W     = 5;
  localparam int CNT_W = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  usr_xfer_ctrl_if #(.W(W), .CNT_W(CNT_W)) bus ();

  usr_xfer_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Universal shift register: 00 hold, 01 left, 10 right, 11 load
  logic [W-1:0] po_q;
  always_ff @(posedge clk) begin
    if (rst) po_q <= '0;
    else begin
      case (bus.usr_sel)
        2'b01:   po_q <= {po_q[W-2:0], bus.usr_si};
        2'b10:   po_q <= {bus.usr_si, po_q[W-1:1]};
        2'b11:   po_q <= bus.usr_pi;
        default: po_q <= po_q;
      endcase
    end
  end
  assign bus.usr_po = po_q;
  assign bus.usr_so = (bus.usr_sel == 2'b01) ? po_q[W-1] : po_q[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] op, input logic [W-1:0] data,
                       input logic [CNT_W-1:0] cnt, input logic si, input logic rot);
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_count = cnt;
    bus.cmd_si    = si;
    bus.cmd_rot   = rot;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b busy=%b rsp_valid=%b, want 0 0 0",
               bus.cmd_ready, bus.busy, bus.rsp_valid);
    end
    checks++;
    if (bus.usr_sel !== 2'b00 || bus.usr_pi !== 5'b00000 || bus.usr_si !== 1'b0) begin
      failures++;
      $display("FAIL reset_usr: sel=%b pi=%b si=%b, want 00 00000 0",
               bus.usr_sel, bus.usr_pi, bus.usr_si);
    end
    checks++;
    if (bus.rsp_data !== 5'b00000 || bus.rsp_shout !== 5'b00000) begin
      failures++;
      $display("FAIL reset_rsp: data=%b shout=%b, want 00000 00000",
               bus.rsp_data, bus.rsp_shout);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_load();
    issue(2'b11, 5'b10110, 3'd0, 1'b0, 1'b0);
    checks++;
    if (bus.usr_sel !== 2'b11 || bus.usr_pi !== 5'b10110 || bus.busy !== 1'b1 ||
        bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_t1: sel=%b pi=%b busy=%b ready=%b, want 11 10110 1 0",
               bus.usr_sel, bus.usr_pi, bus.busy, bus.cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.usr_sel !== 2'b00 || bus.rsp_data !== 5'b10110 ||
        bus.rsp_shout !== 5'b00000) begin
      failures++;
      $display("FAIL load_rsp: valid=%b sel=%b data=%b shout=%b, want 1 00 10110 00000",
               bus.rsp_valid, bus.usr_sel, bus.rsp_data, bus.rsp_shout);
    end
    handshake();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL load_after: ready=%b valid=%b busy=%b, want 1 0 0",
               bus.cmd_ready, bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_shl();
    issue(2'b01, 5'b00000, 3'd2, 1'b1, 1'b0);
    checks++;
    if (bus.usr_sel !== 2'b01 || bus.usr_si !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL shl_t1: sel=%b si=%b valid=%b, want 01 1 0",
               bus.usr_sel, bus.usr_si, bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.usr_sel !== 2'b01 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL shl_t2: sel=%b valid=%b, want 01 0", bus.usr_sel, bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.usr_sel !== 2'b00 || bus.rsp_data !== 5'b11011 ||
        bus.rsp_shout !== 5'b00010) begin
      failures++;
      $display("FAIL shl_rsp: valid=%b sel=%b data=%b shout=%b, want 1 00 11011 00010",
               bus.rsp_valid, bus.usr_sel, bus.rsp_data, bus.rsp_shout);
    end
    handshake();
  endtask

  task automatic test_shr_rot();
    logic [4:0] si_seq;
    logic       sel_bad;
    si_seq  = '0;
    sel_bad = 1'b0;
    issue(2'b11, 5'b10110, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    handshake();
    issue(2'b10, 5'b00000, 3'd5, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      si_seq = {si_seq[3:0], bus.usr_si};
      if (bus.usr_sel !== 2'b10) sel_bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (sel_bad !== 1'b0 || si_seq !== 5'b01101) begin
      failures++;
      $display("FAIL shr_rot_drive: sel_bad=%b si_seq=%b, want 0 01101", sel_bad, si_seq);
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 5'b10110 || bus.rsp_shout !== 5'b01101) begin
      failures++;
      $display("FAIL shr_rot_rsp: valid=%b data=%b shout=%b, want 1 10110 01101",
               bus.rsp_valid, bus.rsp_data, bus.rsp_shout);
    end
    handshake();
  endtask

  task automatic test_read_zero();
    issue(2'b00, 5'b11111, 3'd3, 1'b1, 1'b0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.usr_sel !== 2'b00 || bus.rsp_data !== 5'b10110 ||
        bus.rsp_shout !== 5'b00000) begin
      failures++;
      $display("FAIL read_rsp: valid=%b sel=%b data=%b shout=%b, want 1 00 10110 00000",
               bus.rsp_valid, bus.usr_sel, bus.rsp_data, bus.rsp_shout);
    end
    handshake();
    issue(2'b01, 5'b00000, 3'd0, 1'b1, 1'b0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.usr_sel !== 2'b00 || bus.rsp_data !== 5'b10110 ||
        bus.rsp_shout !== 5'b00000) begin
      failures++;
      $display("FAIL shl0_rsp: valid=%b sel=%b data=%b shout=%b, want 1 00 10110 00000",
               bus.rsp_valid, bus.usr_sel, bus.rsp_data, bus.rsp_shout);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    logic hold_bad;
    hold_bad = 1'b0;
    issue(2'b01, 5'b00000, 3'd1, 1'b0, 1'b0);
    checks++;
    if (bus.usr_sel !== 2'b01) begin
      failures++;
      $display("FAIL bp_shift: sel=%b want 01", bus.usr_sel);
    end
    @(negedge clk);
    // A READ is offered throughout the stall and must wait its turn
    bus.cmd_op    = 2'b00;
    bus.cmd_count = 3'd0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 5'b01100 || bus.rsp_shout !== 5'b00001 ||
          bus.cmd_ready !== 1'b0 || bus.usr_sel !== 2'b00) hold_bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (hold_bad !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold: unstable=%b want 0 (valid=%b data=%b shout=%b)",
               hold_bad, bus.rsp_valid, bus.rsp_data, bus.rsp_shout);
    end
    handshake();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_after: got %b want 1", bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 5'b01100 || bus.rsp_shout !== 5'b00000) begin
      failures++;
      $display("FAIL bp_pending_read: valid=%b data=%b shout=%b, want 1 01100 00000",
               bus.rsp_valid, bus.rsp_data, bus.rsp_shout);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    logic saw_rsp;
    saw_rsp = 1'b0;
    issue(2'b01, 5'b00000, 3'd7, 1'b1, 1'b0);
    checks++;
    if (bus.usr_sel !== 2'b01 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_shift: sel=%b busy=%b, want 01 1", bus.usr_sel, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.usr_sel !== 2'b00) begin
      failures++;
      $display("FAIL mid_rst_sel: got %b want 00", bus.usr_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.usr_po !== 5'b00000 ||
        bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_after: busy=%b ready=%b po=%b valid=%b, want 0 1 00000 0",
               bus.busy, bus.cmd_ready, bus.usr_po, bus.rsp_valid);
    end
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid !== 1'b0) saw_rsp = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_rsp !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_rsp: rsp_valid seen=%b want 0", saw_rsp);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = '0;
    bus.cmd_count = '0;
    bus.cmd_si    = 1'b0;
    bus.cmd_rot   = 1'b0;
    bus.rsp_ready = 1'b0;

    test_reset();
    test_load();
    test_shl();
    test_shr_rot();
    test_read_zero();
    test_backpressure();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usr_xfer_ctrl.md
# usr_xfer_ctrl

Command sequencer for the W-bit universal shift register: accepts load/shift/rotate/read commands over a valid/ready interface and drives the register's sel/PI/SI controls cycle by cycle. It captures the bits that leave the serial output and returns the final parallel word plus the shifted-out bits over a valid/ready response interface. It sits between a bus-side requester and one shift register instance. Both blocks share clk and rst.

## Interface
- W, 5: shift register width.
- CNT_W, 3: width of the shift-count field. Maximum shifts per command is 2^CNT_W-1.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 READ, 01 SHL, 10 SHR, 11 LOAD. This encoding matches the register's sel codes.
- cmd_data  in  W  parallel word for LOAD; ignored otherwise.
- cmd_count  in  CNT_W  number of shift cycles for SHL/SHR; ignored otherwise.
- cmd_si  in  1  fill bit for SHL/SHR when cmd_rot=0.
- cmd_rot  in  1  1: rotate, with SI fed from the register's SO.
- usr_sel  out  2  to register sel.
- usr_pi  out  W  to register PI.
- usr_si  out  1  to register SI.
- usr_po  in  W  from register PO.
- usr_so  in  1  from register SO. SO is PO[W-1] when sel=01, else PO[0].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_data  out  W  register contents after the command (usr_po).
- rsp_shout  out  W  last W bits shifted out; the newest bit is in the LSB.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states and their register controls:
  - IDLE: cmd_ready=1.
  - LOAD: usr_sel=11, usr_pi=latched data.
  - SHIFT: usr_sel=latched op (01 or 10).
  - RESP: rsp_valid=1.
- usr_sel=00 (hold) in every state except LOAD and SHIFT.
- usr_pi=0 outside LOAD. usr_si=0 outside SHIFT.
- On command acceptance in IDLE:
  - Latch op, data, count, si and rot into internal registers.
  - Clear the capture register cap to 0.
- Transitions from IDLE on acceptance:
  - LOAD goes to LOAD.
  - SHL/SHR with count>0 goes to SHIFT, with the remaining-shift counter set to count.
  - READ, or SHL/SHR with count=0, goes directly to RESP. The register is untouched.
- LOAD: one cycle, then RESP.
- SHIFT, each cycle:
  - usr_si = rot ? usr_so : si.
  - cap <= {cap[W-2:0], usr_so}.
  - Decrement the counter.
  - When the counter reaches 1, go to RESP on the next edge.
- Counts greater than W are legal. Extra shifts keep filling, and cap holds only the last W bits out.
- RESP:
  - rsp_data=usr_po, which is stable because sel=00.
  - rsp_shout=cap.
  - Hold until rsp_ready, then go to IDLE on the next edge.
- No command is accepted while a response is pending or an operation is in flight.
- Rotate semantics:
  - SHL with rot=1 rotates left, since SI=PO[W-1].
  - SHR with rot=1 rotates right, since SI=PO[0].
  - The SO-to-SI path is combinational but has no loop, because SO depends only on registered sel and PO.

## Timing
- Reset values:
  - State IDLE, counter 0, cap 0, latched fields 0.
  - usr_sel=00, usr_pi=0, usr_si=0.
  - rsp_valid=0, rsp_data follows usr_po (0 after the register's reset), rsp_shout=0.
  - busy=0, and cmd_ready=0 while rst=1.
- cmd_ready is high from the first cycle after rst deasserts.
- Latency, with acceptance in cycle T:
  - READ or count=0: rsp_valid in T+1.
  - LOAD: sel=11 in T+1, rsp_valid in T+2.
  - Shift by n: sel active in T+1..T+n, rsp_valid in T+n+1.
- After the response handshake in cycle R, cmd_ready is high in R+1. There is no back-to-back overlap.
- rsp_valid, rsp_data and rsp_shout stay stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation:
  - The command is aborted and no response is produced.
  - usr_sel=00 in the reset cycle.
  - The register is cleared by the shared rst.
  - State is IDLE on the next cycle.
- cmd_valid while busy has no effect. The offered command stays pending until cmd_ready.

## Test plan
- rst, then LOAD data=10110 -> usr_sel=11 for 1 cycle; rsp_valid at T+2 with rsp_data=10110, rsp_shout=00000.
- Then SHL count=2 si=1 rot=0 -> usr_sel=01 for 2 cycles; rsp_data=11011, rsp_shout=00010; rsp_valid at T+3.
- From 10110, SHR count=5 rot=1 -> rsp_data=10110, rsp_shout=01101 (bits out 0,1,1,0,1).
- READ, and SHL count=0 -> rsp_valid at T+1; rsp_data unchanged; usr_sel stays 00 throughout.
- Response backpressure: rsp_ready low for 4 cycles -> rsp_valid/rsp_data/rsp_shout stable, cmd_ready=0, usr_sel=00; cmd_ready=1 the cycle after the handshake.
- SHL count=7 with rst pulsed on the 3rd shift cycle -> no rsp_valid, usr_po=0, busy=0 and cmd_ready=1 the cycle after rst drops.
